layer0_input_packer: RTL

Input stage directly upstream of the layer-0 neuron LUTs. It accepts one raw feature per beat over a valid/ready stream, quantizes each feature to Q_BITS, and packs a full frame into the flat vector that the layer-0 neurons slice into their 6-bit inputs. It double-buffers, so the next frame can assemble while the previous one waits on the downstream handshake. It also detects framing errors and discards malformed frames.

---
 rtl/layer0_input_packer.sv | 88 ++++++++
 1 files changed

// File: rtl/layer0_input_packer.sv
// layer0_input_packer: quantizes a stream of raw features and packs each complete frame into one double-buffered flat vector, dropping malformed frames.
module layer0_input_packer #(
    parameter int N_FEATURES = 49,
    parameter int IN_WIDTH   = 8,
    parameter int Q_BITS     = 2,
    parameter int LO         = 0,
    parameter int SHIFT      = 6
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [IN_WIDTH-1:0]          s_data,
    input  logic                         s_last,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [N_FEATURES*Q_BITS-1:0] m_data,
    output logic                         err,
    output logic [7:0]                   err_cnt
);
    localparam int IW = $clog2(N_FEATURES);
    localparam logic [IW-1:0] LAST = IW'(N_FEATURES - 1);
    localparam logic [IN_WIDTH-1:0] LO_V = IN_WIDTH'(LO);
    localparam logic [IN_WIDTH-1:0] QMAX = IN_WIDTH'((1 << Q_BITS) - 1);
    typedef enum logic [1:0] {FILL, DISCARD, PEND} state_t;
    state_t state, state_nx;
    logic [IW-1:0] idx, idx_nx;
    logic [N_FEATURES*Q_BITS-1:0] a, a_nx;
    logic [IN_WIDTH-1:0] d, sh;
    logic [Q_BITS-1:0] q;
    logic acc, load, err_nx;
    assign d = s_data >= LO_V ? s_data - LO_V : '0;
    assign sh = d >> SHIFT;
    assign q = sh > QMAX ? QMAX[Q_BITS-1:0] : sh[Q_BITS-1:0];
    assign s_ready = state != PEND;
    assign acc = s_valid && s_ready;
    always_comb begin
        state_nx = state;
        idx_nx = idx;
        a_nx = a;
        load = 1'b0;
        err_nx = 1'b0;
        case (state)
            FILL: if (acc) begin
                a_nx[idx*Q_BITS +: Q_BITS] = q;
                idx_nx = (s_last || idx == LAST) ? '0 : idx + 1'b1;
                if (s_last && idx == LAST) begin
                    load = !m_valid || m_ready;
                    state_nx = load ? FILL : PEND;
                end else if (s_last) begin
                    err_nx = 1'b1;
                end else if (idx == LAST) begin
                    err_nx = 1'b1;
                    state_nx = DISCARD;
                end
            end
            DISCARD: if (acc && s_last) state_nx = FILL;
            // a parked frame moves only once the previous transfer has emptied O
            default: if (!m_valid) begin
                load = 1'b1;
                state_nx = FILL;
            end
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;
            idx <= '0;
            a <= '0;
            m_valid <= 1'b0;
            m_data <= '0;
            err <= 1'b0;
            err_cnt <= '0;
        end else begin
            state <= state_nx;
            idx <= idx_nx;
            a <= a_nx;
            err <= err_nx;
            if (err_nx && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            if (load) begin
                m_valid <= 1'b1;
                m_data <= a_nx;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end
endmodule
